// File: rtl/demux8_32bit_reg_pkg.sv
// Shared constants and the lane-select decode for the registered 1-to-8 word distributor.
// Pure declarations: no latency, no state, no backpressure.
// Lane count and select width are fixed by the 8-lane datapath. The default word width is 32.
package demux8_32bit_reg_pkg;

    localparam int DEMUX_LANES = 8;
    localparam int DEMUX_SEL_W = 3;
    localparam int DEMUX_WIDTH = 32;

    typedef logic [DEMUX_LANES-1:0] lane_mask_t;
    typedef logic [DEMUX_SEL_W-1:0] lane_sel_t;

    function automatic lane_mask_t lane_decode(input lane_sel_t sel);
        lane_mask_t mask;
        mask      = '0;
        mask[sel] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/demux8_32bit_reg_lane.sv
// One holding register plus full flag for a single distributor lane.
// Latency: load-to-valid is 1 cycle. The register holds its word after drain.
// Backpressure: valid stays high until ack. A same-cycle load and ack keeps valid set and takes the new word.
module demux_lane_32bit
    import demux8_32bit_reg_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             ack,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid,
    output logic [WIDTH-1:0] data_out
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid    <= 1'b0;
            data_out <= '0;
        end else if (load) begin
            valid    <= 1'b1;
            data_out <= data_in;
        end else if (ack) begin
            valid    <= 1'b0;
        end
    end

endmodule

// File: rtl/demux8_32bit_reg.sv
// Registered 1-to-8 distributor: steers one word per cycle into the selected lane's holding register.
// Latency: accept-to-out_valid is 1 cycle. busy is a combinational OR of the lane valid flags.
// Backpressure: in_ready = target lane empty or draining this cycle. Optional broadcast (DEMUX_BCAST_EN) waits for all lanes.
module demux8_32bit_reg
    import demux8_32bit_reg_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DEMUX_SEL_W-1:0]       select,
    input  logic                         bcast,
    input  logic [WIDTH-1:0]             data_in,
    output logic [DEMUX_LANES*WIDTH-1:0] data_out,
    output logic [DEMUX_LANES-1:0]       out_valid,
    input  logic [DEMUX_LANES-1:0]       out_ack,
    output logic                         busy
);

    lane_mask_t lane_free;
    lane_mask_t target_mask;
    lane_mask_t lane_load;
    logic       accept;

    // A lane can take a new word when it is empty or being drained in the same cycle.
    assign lane_free = ~out_valid | out_ack;

`ifdef DEMUX_BCAST_EN
    assign in_ready    = bcast ? (&lane_free) : lane_free[select];
    assign target_mask = bcast ? '1 : lane_decode(select);
`else
    logic unused_bcast;
    assign unused_bcast = bcast;
    assign in_ready     = lane_free[select];
    assign target_mask  = lane_decode(select);
`endif

    assign accept    = in_valid & in_ready;
    assign lane_load = {DEMUX_LANES{accept}} & target_mask;
    assign busy      = |out_valid;

    for (genvar i = 0; i < DEMUX_LANES; i++) begin : g_lane
        demux_lane_32bit #(
            .WIDTH(WIDTH)
        ) u_lane (
            .clock   (clock),
            .reset_n (reset_n),
            .load    (lane_load[i]),
            .ack     (out_ack[i]),
            .data_in (data_in),
            .valid   (out_valid[i]),
            .data_out(data_out[WIDTH*i +: WIDTH])
        );
    end

endmodule

// File: tb/tb_demux8_32bit_reg.sv
// Directed bench for demux8_32bit_reg. The bench covers reset, accept and stall, refill-on-drain, fill-all, broadcast or its absence, ignored acks, and async reset.
// Expected lane contents are kept in exp_lane and updated by hand alongside each stimulus step.
module tb_demux8_32bit_reg;

    localparam int W = 32;

    logic           clock    = 1'b0;
    logic           reset_n  = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [2:0]     select   = 3'd0;
    logic           bcast    = 1'b0;
    logic [W-1:0]   data_in  = '0;
    logic [8*W-1:0] data_out;
    logic [7:0]     out_valid;
    logic [7:0]     out_ack  = 8'h00;
    logic           busy;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] exp_lane [8];

    demux8_32bit_reg #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .select   (select),
        .bcast    (bcast),
        .data_in  (data_in),
        .data_out (data_out),
        .out_valid(out_valid),
        .out_ack  (out_ack),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [255:0] lanes_packed();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = exp_lane[i];
        return r;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_ready_all(input string tag, input logic exp_v);
        for (int s = 0; s < 8; s++) begin
            select = 3'(s);
            #1;
            check_eq($sformatf("%s_sel%0d", tag, s), {255'd0, in_ready}, {255'd0, exp_v});
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) exp_lane[i] = 32'h0;

        // Reset state
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_valid", {248'd0, out_valid}, 256'h0);
        check_eq("rst_data", data_out, 256'h0);
        check_eq("rst_busy", {255'd0, busy}, 256'h0);
        check_ready_all("rst_ready", 1'b1);
        @(negedge clock);
        reset_n = 1'b1;
        step();

        // Accept to lane 3, then stall a second word until ack
        select = 3'd3; data_in = 32'hDEADBEEF; in_valid = 1'b1;
        #1 check_eq("l3_ready0", {255'd0, in_ready}, 256'h1);
        step();
        exp_lane[3] = 32'hDEADBEEF;
        check_eq("l3_valid", {248'd0, out_valid}, 256'h08);
        check_eq("l3_data", {224'd0, data_out[96 +: 32]}, 256'hDEADBEEF);
        check_eq("l3_busy", {255'd0, busy}, 256'h1);
        data_in = 32'h12345678;
        #1 check_eq("l3_stall_ready", {255'd0, in_ready}, 256'h0);
        step(); step();
        check_eq("l3_stall_valid", {248'd0, out_valid}, 256'h08);
        check_eq("l3_stall_data", data_out, lanes_packed());
        out_ack = 8'h08;
        #1 check_eq("l3_refill_ready", {255'd0, in_ready}, 256'h1);
        step();
        exp_lane[3] = 32'h12345678;
        check_eq("l3_refill_valid", {248'd0, out_valid}, 256'h08);
        check_eq("l3_refill_data", {224'd0, data_out[96 +: 32]}, 256'h12345678);
        in_valid = 1'b0;
        step();
        check_eq("l3_drain_valid", {248'd0, out_valid}, 256'h00);
        check_eq("l3_drain_hold", data_out, lanes_packed());
        check_eq("l3_drain_busy", {255'd0, busy}, 256'h0);

        // Acks on empty lanes are ignored
        out_ack = 8'hFF;
        step(); step();
        check_eq("ack_idle_valid", {248'd0, out_valid}, 256'h00);
        check_eq("ack_idle_data", data_out, lanes_packed());
        check_eq("ack_idle_busy", {255'd0, busy}, 256'h0);
        out_ack = 8'h00;

        // Back-to-back fill of lanes 0..7
        for (int i = 0; i < 8; i++) begin
            select = 3'(i); data_in = 32'(i + 1); in_valid = 1'b1;
            #1 check_eq($sformatf("fill_ready%0d", i), {255'd0, in_ready}, 256'h1);
            step();
            exp_lane[i] = 32'(i + 1);
            check_eq($sformatf("fill_valid%0d", i), {248'd0, out_valid}, 256'((1 << (i + 1)) - 1));
        end
        in_valid = 1'b0;
        check_eq("fill_busy", {255'd0, busy}, 256'h1);
        check_eq("fill_data", data_out, lanes_packed());
        check_ready_all("full_ready", 1'b0);

        // Leave only lane 6 full, then try a broadcast aimed at select 2
        out_ack = 8'hBF;
        step();
        out_ack = 8'h00;
        check_eq("bc_pre_valid", {248'd0, out_valid}, 256'h40);
        bcast = 1'b1; select = 3'd2; data_in = 32'hA5A5A5A5; in_valid = 1'b1;
`ifdef DEMUX_BCAST_EN
        #1 check_eq("bc_stall_ready", {255'd0, in_ready}, 256'h0);
        step();
        check_eq("bc_stall_valid", {248'd0, out_valid}, 256'h40);
        out_ack = 8'h40;
        #1 check_eq("bc_go_ready", {255'd0, in_ready}, 256'h1);
        step();
        in_valid = 1'b0; out_ack = 8'h00;
        for (int i = 0; i < 8; i++) exp_lane[i] = 32'hA5A5A5A5;
        check_eq("bc_valid", {248'd0, out_valid}, 256'hFF);
        check_eq("bc_data", data_out, lanes_packed());
`else
        #1 check_eq("nobc_ready", {255'd0, in_ready}, 256'h1);
        step();
        in_valid = 1'b0;
        exp_lane[2] = 32'hA5A5A5A5;
        check_eq("nobc_valid", {248'd0, out_valid}, 256'h44);
        check_eq("nobc_data", data_out, lanes_packed());
`endif
        bcast = 1'b0;
        out_ack = 8'hFF;
        step();
        check_eq("clear_valid", {248'd0, out_valid}, 256'h00);

        // Single lane at full rate with its ack held high
        out_ack = 8'h01; select = 3'd0;
        for (int k = 0; k < 4; k++) begin
            data_in = 32'h100 + 32'(k); in_valid = 1'b1;
            #1 check_eq($sformatf("thru_ready%0d", k), {255'd0, in_ready}, 256'h1);
            step();
            check_eq($sformatf("thru_valid%0d", k), {248'd0, out_valid}, 256'h01);
            check_eq($sformatf("thru_data%0d", k), {224'd0, data_out[0 +: 32]}, 256'(32'h100 + 32'(k)));
        end
        in_valid = 1'b0;
        step();
        exp_lane[0] = 32'h103;
        check_eq("thru_drain", {248'd0, out_valid}, 256'h00);
        out_ack = 8'h00;

        // Async reset mid-stream with lanes 2 and 5 full and an accept in flight
        select = 3'd2; data_in = 32'h22222222; in_valid = 1'b1;
        step();
        select = 3'd5; data_in = 32'h55555555;
        step();
        check_eq("mid_valid", {248'd0, out_valid}, 256'h24);
        select = 3'd1; data_in = 32'h11111111; out_ack = 8'h04;
        #2 reset_n = 1'b0;
        #1;
        check_eq("arst_valid", {248'd0, out_valid}, 256'h00);
        check_eq("arst_data", data_out, 256'h0);
        check_eq("arst_busy", {255'd0, busy}, 256'h0);
        step();
        check_eq("arst_hold_valid", {248'd0, out_valid}, 256'h00);
        in_valid = 1'b0; out_ack = 8'h00;
        @(negedge clock);
        reset_n = 1'b1;
        check_ready_all("post_rst_ready", 1'b1);
        step();
        check_eq("post_rst_valid", {248'd0, out_valid}, 256'h00);
        check_eq("post_rst_data", data_out, 256'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
